// File: rtl/dlx_mem_pkg.sv
// rtl/dlx_mem_pkg.sv - access-size encoding, controller states and lane-select helpers for the data-memory path
package dlx_mem_pkg;

  localparam logic [0:1] SIZE_BYTE = 2'b00;
  localparam logic [0:1] SIZE_HALF = 2'b01;
  localparam logic [0:1] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LD_WAIT   = 2'b01,
    ST_RMW_MERGE = 2'b10
  } dmem_state_t;

  // Byte offset of the selected lane; low bits a size cannot address are forced to 0.
  function automatic logic [0:1] lane_offset(input logic [0:1] size, input logic [0:1] off);
    case (size)
      SIZE_BYTE: return off;
      SIZE_HALF: return {off[0], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [0:1] size, input logic [0:1] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[1];
      default:   return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - big-endian load lane extract with sign/zero extend, and store lane merge
module dmem_lane_align
  import dlx_mem_pkg::*;
(
  input  logic [0:1]  size,
  input  logic [0:1]  off,
  input  logic        ext,
  input  logic [0:31] rd_word,
  input  logic [0:31] wdata,
  output logic [0:31] ld_data,
  output logic [0:31] st_word
);

  logic [0:7]  byte_sel;
  logic [0:15] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = rd_word[0:7];
      2'd1:    byte_sel = rd_word[8:15];
      2'd2:    byte_sel = rd_word[16:23];
      default: byte_sel = rd_word[24:31];
    endcase
    half_sel = off[0] ? rd_word[16:31] : rd_word[0:15];

    case (size)
      SIZE_BYTE: ld_data = {{24{ext & byte_sel[0]}}, byte_sel};
      SIZE_HALF: ld_data = {{16{ext & half_sel[0]}}, half_sel};
      default:   ld_data = rd_word;
    endcase

    // Store data arrives right-justified; only the addressed lane is replaced.
    st_word = rd_word;
    case (size)
      SIZE_BYTE: begin
        case (off)
          2'd0:    st_word[0:7]   = wdata[24:31];
          2'd1:    st_word[8:15]  = wdata[24:31];
          2'd2:    st_word[16:23] = wdata[24:31];
          default: st_word[24:31] = wdata[24:31];
        endcase
      end
      SIZE_HALF: begin
        if (off[0]) st_word[16:31] = wdata[16:31];
        else        st_word[0:15]  = wdata[16:31];
      end
      default: st_word = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// rtl/dmem_rmw_ctrl.sv - DLX data-memory controller: sub-word loads, read-modify-write stores, pipeline stall
// Optional misaligned-access rejection: define DMEM_ALIGN_CHECK_EN.
module dmem_rmw_ctrl
  import dlx_mem_pkg::*;
#(
  parameter int WORD_ADDR_W = 13,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req,
  input  logic [0:31]            mem_addr,
  input  logic [0:31]            mem_wdata,
  input  logic                   mem_we,
  input  logic [0:1]             mem_size,
  input  logic                   mem_ext,
  output logic                   stall,
  output logic [0:31]            rdata,
  output logic                   rdata_valid,
  output logic                   align_err,
  output logic [0:WORD_ADDR_W-1] sram_addr,
  output logic                   sram_re,
  output logic                   sram_we,
  output logic [0:31]            sram_wdata,
  input  logic [0:31]            sram_rdata,
  output logic [0:CNT_W-1]       load_cnt,
  output logic [0:CNT_W-1]       store_cnt
);

  dmem_state_t            state;
  logic [0:WORD_ADDR_W-1] addr_q;
  logic [0:1]             off_q;
  logic [0:1]             size_q;
  logic                   ext_q;
  logic [0:31]            wdata_q;
  logic [0:31]            ld_data;
  logic [0:31]            st_word;
  logic                   mis;
  logic                   is_word;
  logic [0:WORD_ADDR_W-1] addr_in;
  logic [0:1]             off_in;
  logic                   unused_addr_hi;

  assign addr_in        = mem_addr[30-WORD_ADDR_W:29];
  assign unused_addr_hi = ^mem_addr[0:29-WORD_ADDR_W];
  assign off_in         = lane_offset(mem_size, mem_addr[30:31]);
  // Reserved size 2'b11 shares the word path.
  assign is_word        = mem_size[0];

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = misaligned(mem_size, mem_addr[30:31]);
`else
  assign mis = 1'b0;
`endif

  function automatic logic [0:CNT_W-1] sat_inc(input logic [0:CNT_W-1] cnt);
    return (&cnt) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  dmem_lane_align u_lane (
    .size    (size_q),
    .off     (off_q),
    .ext     (ext_q),
    .rd_word (sram_rdata),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      off_q     <= '0;
      size_q    <= SIZE_BYTE;
      ext_q     <= 1'b0;
      wdata_q   <= '0;
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_req && !mis) begin
            addr_q  <= addr_in;
            off_q   <= off_in;
            size_q  <= mem_size;
            ext_q   <= mem_ext;
            wdata_q <= mem_wdata;
            if (mem_we && is_word) store_cnt <= sat_inc(store_cnt);
            else if (mem_we)       state     <= ST_RMW_MERGE;
            else                   state     <= ST_LD_WAIT;
          end
        end
        ST_LD_WAIT: begin
          load_cnt <= sat_inc(load_cnt);
          state    <= ST_IDLE;
        end
        ST_RMW_MERGE: begin
          store_cnt <= sat_inc(store_cnt);
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are gated by reset so an access in flight is dropped without a write.
  always_comb begin
    stall       = 1'b0;
    rdata       = '0;
    rdata_valid = 1'b0;
    align_err   = 1'b0;
    sram_re     = 1'b0;
    sram_we     = 1'b0;
    sram_wdata  = '0;
    sram_addr   = (state == ST_IDLE) ? addr_in : addr_q;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          if (mem_req) begin
            if (mis) begin
              align_err = 1'b1;
            end else if (mem_we && is_word) begin
              sram_we    = 1'b1;
              sram_wdata = mem_wdata;
            end else begin
              sram_re = 1'b1;
              stall   = 1'b1;
            end
          end
        end
        ST_LD_WAIT: begin
          rdata_valid = 1'b1;
          rdata       = ld_data;
        end
        ST_RMW_MERGE: begin
          sram_we    = 1'b1;
          sram_wdata = st_word;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// tb/tb_dmem_rmw_ctrl.sv - directed vectors for dmem_rmw_ctrl against a one-cycle-latency SRAM model
module tb_dmem_rmw_ctrl;
  import dlx_mem_pkg::*;

  localparam int WAW = 13;
  localparam int CW  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            mem_req;
  logic [0:31]     mem_addr;
  logic [0:31]     mem_wdata;
  logic            mem_we;
  logic [0:1]      mem_size;
  logic            mem_ext;
  logic            stall;
  logic [0:31]     rdata;
  logic            rdata_valid;
  logic            align_err;
  logic [0:WAW-1]  sram_addr;
  logic            sram_re;
  logic            sram_we;
  logic [0:31]     sram_wdata;
  logic [0:31]     sram_rdata;
  logic [0:CW-1]   load_cnt;
  logic [0:CW-1]   store_cnt;

  logic [0:31] mem [0:(1<<WAW)-1];
  int vectors = 0;
  int errors  = 0;
  int exp_ld  = 0;
  int exp_st  = 0;

  always #5 clk = ~clk;

  dmem_rmw_ctrl #(.WORD_ADDR_W(WAW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_size(mem_size), .mem_ext(mem_ext),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .align_err(align_err),
    .sram_addr(sram_addr), .sram_re(sram_re), .sram_we(sram_we), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_re) sram_rdata <= mem[sram_addr];
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v == (1 << CW) - 1) ? v : v + 1;
  endfunction

  task automatic drive(input logic req, input logic we, input logic [0:1] size,
                       input logic ext, input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk); #1;
    mem_req = req; mem_we = we; mem_size = size; mem_ext = ext;
    mem_addr = addr; mem_wdata = wd;
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, SIZE_BYTE, 1'b0, 32'h0, 32'h0);
    check_vec("idle_stall", stall, 0);
    check_vec("load_cnt", load_cnt, exp_ld);
    check_vec("store_cnt", store_cnt, exp_st);
  endtask

  task automatic sw(input logic [31:0] addr, input logic [31:0] data);
    drive(1'b1, 1'b1, SIZE_WORD, 1'b0, addr, data);
    check_vec("sw_we", sram_we, 1);
    check_vec("sw_stall", stall, 0);
    check_vec("sw_wdata", sram_wdata, data);
    exp_st = sat(exp_st);
    idle_cycle();
  endtask

  task automatic ld(input logic [31:0] addr, input logic [0:1] size, input logic ext,
                    input logic [31:0] exp);
    drive(1'b1, 1'b0, size, ext, addr, 32'h0);
    check_vec("ld_stall", stall, 1);
    check_vec("ld_re", sram_re, 1);
    drive(1'b1, 1'b0, size, ext, addr, 32'h0);
    check_vec("ld_valid", rdata_valid, 1);
    check_vec("ld_wait_stall", stall, 0);
    check_vec("ld_rdata", rdata, exp);
    exp_ld = sat(exp_ld);
    idle_cycle();
  endtask

  task automatic sub_st(input logic [31:0] addr, input logic [0:1] size,
                        input logic [31:0] data, input logic [31:0] exp_word);
    drive(1'b1, 1'b1, size, 1'b0, addr, data);
    check_vec("rmw_stall", stall, 1);
    check_vec("rmw_re", sram_re, 1);
    check_vec("rmw_no_we", sram_we, 0);
    drive(1'b1, 1'b1, size, 1'b0, addr, data);
    check_vec("rmw_we", sram_we, 1);
    check_vec("rmw_merge_stall", stall, 0);
    check_vec("rmw_wdata", sram_wdata, exp_word);
    exp_st = sat(exp_st);
    idle_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_size = SIZE_BYTE;
    mem_ext = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_vec("rst_stall", stall, 0);
    check_vec("rst_valid", rdata_valid, 0);
    check_vec("rst_align", align_err, 0);
    check_vec("rst_re", sram_re, 0);
    check_vec("rst_we", sram_we, 0);
    check_vec("rst_rdata", rdata, 0);
    check_vec("rst_wdata", sram_wdata, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_vec("rst_load_cnt", load_cnt, 0);
    check_vec("rst_store_cnt", store_cnt, 0);

    sw(32'h2000, 32'hDEADBEEF);
    ld(32'h2000, SIZE_WORD, 1'b0, 32'hDEADBEEF);
    check_vec("t1_counts", {store_cnt, load_cnt}, 8'h11);

    sw(32'h2004, 32'h80F17F01);
    ld(32'h2005, SIZE_BYTE, 1'b1, 32'hFFFFFFF1);
    ld(32'h2005, SIZE_BYTE, 1'b0, 32'h000000F1);
    ld(32'h2006, SIZE_HALF, 1'b1, 32'h00007F01);
    ld(32'h2004, SIZE_HALF, 1'b1, 32'hFFFF80F1);
    ld(32'h2007, SIZE_BYTE, 1'b1, 32'h00000001);

    sw(32'h2004, 32'h11223344);
    sub_st(32'h2006, SIZE_BYTE, 32'h000000AA, 32'h1122AA44);
    sub_st(32'h2004, SIZE_HALF, 32'h00005566, 32'h5566AA44);
    ld(32'h2004, SIZE_WORD, 1'b0, 32'h5566AA44);

    // Reset lands while the byte store is in its merge cycle.
    drive(1'b1, 1'b1, SIZE_BYTE, 1'b0, 32'h2007, 32'h00000077);
    check_vec("abort_stall", stall, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_vec("abort_we", sram_we, 0);
    @(posedge clk); #1 reset = 1'b0; mem_req = 1'b0;
    exp_st = 0; exp_ld = 0;
    @(negedge clk);
    check_vec("abort_idle_stall", stall, 0);
    check_vec("abort_store_cnt", store_cnt, 0);
    ld(32'h2004, SIZE_WORD, 1'b0, 32'h5566AA44);

`ifdef DMEM_ALIGN_CHECK_EN
    drive(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h2002, 32'h0);
    check_vec("align_err", align_err, 1);
    check_vec("align_no_re", sram_re, 0);
    check_vec("align_stall", stall, 0);
    check_vec("align_valid", rdata_valid, 0);
    idle_cycle();
    check_vec("align_err_clr", align_err, 0);
`else
    ld(32'h2002, SIZE_WORD, 1'b0, 32'hDEADBEEF);
    ld(32'h2005, SIZE_HALF, 1'b0, 32'h00005566);
`endif

    for (int i = 0; i < 14; i++) sw(32'h2010, 32'h100 + i);
    check_vec("sat_preload", store_cnt, 14);
    for (int i = 0; i < 3; i++) sw(32'h2010, 32'h200 + i);
    check_vec("sat_store_cnt", store_cnt, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
